// File: rtl/sram_req_ctrl_pkg.sv
// Shared constants and FSM state type for the SRAM request controller.
package sram_ctrl_pkg;
    localparam int ADDR_WIDTH = 9;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WMASKS = DATA_WIDTH / 8;

    typedef enum logic {INIT, RUN} ctrl_state_e;
endpackage

// File: rtl/sram_req_ctrl_if.sv
// Request/response stream between an upstream client (master) and sram_req_ctrl (slave).
interface sram_req_ctrl_if #(
    parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
    parameter int NUM_WMASKS = sram_ctrl_pkg::NUM_WMASKS
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [NUM_WMASKS-1:0] req_wmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding SRAM read data; exposes occupancy for flow control.
module sram_rsp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign dout = mem[rptr];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == FULL));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count == '0));
endmodule

// File: rtl/sram_req_ctrl.sv
// Front-end for the dual-port SRAM macro: writes on port 0, reads on port 1, read data
// buffered so downstream stalls never drop it. Define SRAM_STATS_EN for request/stall counters.
module sram_req_ctrl #(
    parameter int ADDR_WIDTH    = sram_ctrl_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH    = sram_ctrl_pkg::DATA_WIDTH,
    parameter int NUM_WMASKS    = sram_ctrl_pkg::NUM_WMASKS,
    parameter int RSP_DEPTH     = 2,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_req_ctrl_if.slave        bus,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
`ifdef SRAM_STATS_EN
    ,
    output logic [31:0]           stat_rd_cnt,
    output logic [31:0]           stat_wr_cnt,
    output logic [31:0]           stat_stall_cnt
`endif
);
    import sram_ctrl_pkg::*;

    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = RSP_DEPTH[CW:0];

    ctrl_state_e           state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  inflight;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic [CW:0]           occupancy;
    logic                  run, pop, rd_room, wr_acc, rd_acc;

    assign run = rst_n && (state == RUN);
    assign pop = bus.rsp_valid && bus.rsp_ready;

    // A pop in the same cycle frees a slot before the new read's data lands,
    // which is what lets a 2-entry FIFO sustain one read per cycle.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign rd_room   = occupancy < DEPTH_V;

    assign bus.req_ready = run && (bus.req_we || rd_room);
    assign wr_acc        = bus.req_valid && bus.req_ready && bus.req_we;
    assign rd_acc        = bus.req_valid && bus.req_ready && !bus.req_we;
    assign bus.rsp_valid = rst_n && (fifo_count != '0);
    assign bus.rsp_rdata = bus.rsp_valid ? fifo_dout : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= (INIT_ON_RESET != 0) ? INIT : RUN;
            init_done <= (INIT_ON_RESET == 0);
            init_cnt  <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= rd_acc;
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (&init_cnt) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Macro pins follow the accept condition so the macro samples on the accepting edge.
    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        sram_csb1   = 1'b1;
        sram_addr1  = bus.req_addr;
        if (rst_n && state == INIT) begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = '1;
            sram_addr0  = init_cnt;
        end else if (wr_acc) begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = bus.req_wmask;
            sram_addr0  = bus.req_addr;
            sram_din0   = bus.req_wdata;
        end else if (rd_acc) begin
            sram_csb1   = 1'b0;
        end
    end

    sram_rsp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .din   (sram_dout1),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

`ifdef SRAM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_rd_cnt    <= '0;
            stat_wr_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (rd_acc && !(&stat_rd_cnt))
                stat_rd_cnt <= stat_rd_cnt + 32'd1;
            if (wr_acc && !(&stat_wr_cnt))
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            if (state == RUN && bus.req_valid && !bus.req_ready && !(&stat_stall_cnt))
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl: SRAM macro model, scoreboard model checked every cycle,
// and directed tests with literal expectations.
module tb_sram_req_ctrl;
    localparam int AW = 9, DW = 32, NM = 4, DEPTH = 2, WORDS = 512;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sram_req_ctrl_if bus();

    logic          init_done, sram_csb0, sram_web0, sram_csb1;
    logic [NM-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0, sram_addr1;
    logic [DW-1:0] sram_din0, sram_dout1;
`ifdef SRAM_STATS_EN
    logic [31:0]   stat_rd_cnt, stat_wr_cnt, stat_stall_cnt;
`endif

    sram_req_ctrl #(.RSP_DEPTH(DEPTH), .INIT_ON_RESET(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .init_done   (init_done),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_csb1   (sram_csb1),
        .sram_addr1  (sram_addr1),
        .sram_dout1  (sram_dout1)
`ifdef SRAM_STATS_EN
        ,
        .stat_rd_cnt    (stat_rd_cnt),
        .stat_wr_cnt    (stat_wr_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    int n_chk, n_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nd,
                                            input logic [NM-1:0] m);
        merge = old;
        for (int b = 0; b < NM; b++)
            if (m[b]) merge[b*8 +: 8] = nd[b*8 +: 8];
    endfunction

    // SRAM macro: garbage at power-up, write on port 0, registered read on port 1.
    logic [DW-1:0] mem [WORDS];
    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom();
        forever begin
            @(posedge clk);
            if (!sram_csb0 && !sram_web0)
                mem[sram_addr0] = merge(mem[sram_addr0], sram_din0, sram_wmask0);
            if (!sram_csb1)
                sram_dout1 <= mem[sram_addr1];
        end
    end

    // Scoreboard model: a flat memory image and a queue of promised responses.
    typedef struct { logic [DW-1:0] data; int cyc; } exp_t;
    logic [DW-1:0] ref_mem [WORDS];
    exp_t          exp_q[$];
    logic [DW-1:0] got_q[$];
    int            got_c[$];
    int            cyc, outstanding, init_ctr;
    bit            in_init;

    always @(negedge clk) begin
        bit            exp_vld, pop, exp_rdy;
        logic [DW-1:0] exp_d;
        exp_t          e;
        cyc++;
        if (!rst_n) begin
            chk("rst_outputs", {bus.req_ready, bus.rsp_valid, sram_csb0, sram_csb1, sram_web0}, 5'b00111);
            chk("rst_rdata", bus.rsp_rdata, 0);
            exp_q.delete();
            outstanding = 0;
            init_ctr    = 0;
            in_init     = 1'b1;
            foreach (ref_mem[i]) ref_mem[i] = '0;
        end else if (in_init) begin
            chk("init_drive",
                {bus.req_ready, init_done, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, sram_csb1},
                {1'b0, 1'b0, 1'b0, 1'b0, 4'hF, init_ctr[8:0], 32'h0, 1'b1});
            init_ctr++;
            if (init_ctr == WORDS) in_init = 1'b0;
        end else begin
            exp_vld = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
            exp_d   = '0;
            if (exp_vld) exp_d = exp_q[0].data;
            pop     = exp_vld && bus.rsp_ready;
            exp_rdy = bus.req_we || ((outstanding - int'(pop)) < DEPTH);
            chk("init_done", init_done, 1);
            chk("rsp_valid", bus.rsp_valid, exp_vld);
            chk("rsp_rdata", bus.rsp_rdata, exp_d);
            chk("req_ready", bus.req_ready, exp_rdy);
            if (bus.req_valid && bus.req_ready && bus.req_we) begin
                chk("wr_port", {sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0, sram_csb1},
                    {2'b00, bus.req_wmask, bus.req_addr, bus.req_wdata, 1'b1});
                ref_mem[bus.req_addr] = merge(ref_mem[bus.req_addr], bus.req_wdata, bus.req_wmask);
            end else if (bus.req_valid && bus.req_ready) begin
                chk("rd_port", {sram_csb1, sram_addr1, sram_csb0}, {1'b0, bus.req_addr, 1'b1});
                e.data = ref_mem[bus.req_addr];
                e.cyc  = cyc + 2;
                exp_q.push_back(e);
                outstanding++;
            end else begin
                chk("idle_port", {sram_csb0, sram_csb1}, 2'b11);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                got_q.push_back(bus.rsp_rdata);
                got_c.push_back(cyc);
            end
            if (pop) begin
                void'(exp_q.pop_front());
                outstanding--;
            end
        end
    end

    task automatic do_req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [NM-1:0] m, output int waits);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wmask = m;
        waits = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            waits++;
            if (waits > 20) begin
                chk("req_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [DW-1:0] d, output int lat);
        d   = '0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                d = bus.rsp_rdata;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (init_done) break;
            n++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int            w, n, lat, acc, mark;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        bit            took;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wmask = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Power-up sweep length, then the top word must read back zero.
        wait_init(n);
        chk("init_cycles", n, 512);
        do_req(1'b0, 9'h1FF, '0, '0, w);
        wait_rsp(d, lat);
        chk("rd_1ff_data", d, 32'h0000_0000);
        chk("rd_1ff_lat", lat, 2);

        // Byte-masked overwrite.
        do_req(1'b1, 9'h010, 32'hDEADBEEF, 4'b1111, w);
        do_req(1'b1, 9'h010, 32'h000000AA, 4'b0001, w);
        do_req(1'b0, 9'h010, '0, '0, w);
        wait_rsp(d, lat);
        chk("mask_merge_data", d, 32'hDEADBEAA);
        chk("mask_merge_lat", lat, 2);

        // Back-to-back reads at full rate.
        for (int i = 0; i < 8; i++) do_req(1'b1, 9'h020 + 9'(i), 32'hC0DE0020 + i, 4'hF, w);
        mark = got_q.size();
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_addr  = 9'h020 + 9'(i);
            @(negedge clk);
            chk("b2b_ready", bus.req_ready, 1);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_count", got_q.size() - mark, 8);
        for (int i = 0; i < 8; i++) begin
            if (got_q.size() > mark + i) begin
                chk("b2b_data", got_q[mark+i], 32'hC0DE0020 + i);
                chk("b2b_consecutive", got_c[mark+i] - got_c[mark], i);
            end
        end

        // Downstream stalled: only RSP_DEPTH reads get in, writes still flow.
        mark          = got_q.size();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        a             = 9'h024;
        bus.req_addr  = a;
        acc           = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            took = bus.req_ready;
            if (took) acc++;
            @(posedge clk); #1;
            if (took) a = a + 9'd1;
            bus.req_addr = a;
        end
        chk("stall_rd_accepted", acc, DEPTH);
        bus.req_we    = 1'b1;
        bus.req_addr  = 9'h030;
        bus.req_wdata = 32'h1234_5678;
        bus.req_wmask = 4'hF;
        @(negedge clk);
        chk("stall_wr_ready", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("stall_drain_count", got_q.size() - mark, 2);
        if (got_q.size() >= mark + 2) begin
            chk("stall_drain_0", got_q[mark], 32'hC0DE0024);
            chk("stall_drain_1", got_q[mark+1], 32'hC0DE0025);
        end

        // Reset lands while a read is in flight.
        mark = got_q.size();
        do_req(1'b0, 9'h021, '0, '0, w);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("restart_addr0", {sram_csb0, sram_web0, sram_addr0}, {2'b00, 9'h000});
        chk("restart_no_rsp", bus.rsp_valid, 0);
        @(posedge clk); #1;
        wait_init(n);
        chk("restart_init_cycles", n, 511);
        chk("restart_rsp_dropped", got_q.size() - mark, 0);

`ifdef SRAM_STATS_EN
        for (int i = 0; i < 3; i++) do_req(1'b1, 9'h040 + 9'(i), 32'h5A5A0000 + i, 4'hF, w);
        for (int i = 0; i < 3; i++) do_req(1'b0, 9'h040 + 9'(i), '0, '0, w);
        repeat (4) @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        do_req(1'b0, 9'h040, '0, '0, w);
        do_req(1'b0, 9'h041, '0, '0, w);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 9'h042;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stats_blocked", bus.req_ready, 0);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        chk("stat_wr_cnt", stat_wr_cnt, 3);
        chk("stat_rd_cnt", stat_rd_cnt, 5);
        chk("stat_stall_cnt", stat_stall_cnt, 4);
        bus.rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
